// File: rtl/stepper_pulse_gen.sv
// Dual-axis STEP/DIR pulse generator: loads a move from the SCARA controller and
// emits lockstep STEP pulses to two drivers while tracking signed joint positions.
module stepper_pulse_gen #(
    parameter int STEP_W    = 32,
    parameter int POS_W     = 32,
    parameter int DIR_SETUP = 50,
    parameter int PULSE_HI  = 100,
    parameter int PULSE_LO  = 100
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [63:0]             m1_steps,
    input  logic [63:0]             m2_steps,
    input  logic                    dir1,
    input  logic                    dir2,
    output logic                    step1_out,
    output logic                    step2_out,
    output logic                    dir1_out,
    output logic                    dir2_out,
    output logic                    stepper_ready,
    output logic                    move_done,
    output logic                    sat,
    output logic signed [POS_W-1:0] pos1,
    output logic signed [POS_W-1:0] pos2
);

    localparam int T_MAX = (DIR_SETUP > PULSE_HI)
                         ? ((DIR_SETUP > PULSE_LO) ? DIR_SETUP : PULSE_LO)
                         : ((PULSE_HI  > PULSE_LO) ? PULSE_HI  : PULSE_LO);
    localparam int TMR_W = $clog2(T_MAX + 1);

    // Timers count down to zero, so each phase loads its length minus one.
    localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] T_HI    = TMR_W'(PULSE_HI - 1);
    localparam logic [TMR_W-1:0] T_LO    = TMR_W'(PULSE_LO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [STEP_W-1:0]  r_cnt1;
    logic [STEP_W-1:0]  r_cnt2;
    logic [POS_W-1:0]   r_pos1;
    logic [POS_W-1:0]   r_pos2;
    logic               r_step1;
    logic               r_step2;
    logic               r_dir1;
    logic               r_dir2;
    logic               r_ready;
    logic               r_done;
    logic               r_sat;

    logic               w_ovf1;
    logic               w_ovf2;
    logic [STEP_W-1:0]  w_load1;
    logic [STEP_W-1:0]  w_load2;
    logic               w_act1;
    logic               w_act2;
    logic               w_tmr_zero;

    // Any set bit above the counter width clamps the count to all-ones.
    assign w_ovf1     = (m1_steps >> STEP_W) != 64'd0;
    assign w_ovf2     = (m2_steps >> STEP_W) != 64'd0;
    assign w_load1    = w_ovf1 ? '1 : m1_steps[STEP_W-1:0];
    assign w_load2    = w_ovf2 ? '1 : m2_steps[STEP_W-1:0];
    assign w_act1     = r_cnt1 != '0;
    assign w_act2     = r_cnt2 != '0;
    assign w_tmr_zero = r_timer == '0;

    // NOTE: every register here is assigned with <= so all state updates
    // within a cycle see the same pre-edge values, whatever the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_pos1  <= '0;
            r_pos2  <= '0;
            r_step1 <= 1'b0;
            r_step2 <= 1'b0;
            r_dir1  <= 1'b0;
            r_dir2  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_cnt1  <= w_load1;
                        r_cnt2  <= w_load2;
                        r_dir1  <= dir1;
                        r_dir2  <= dir2;
                        r_sat   <= w_ovf1 | w_ovf2;
                        r_ready <= 1'b0;
                        r_timer <= T_SETUP;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (abort) begin
                        r_cnt1  <= '0;
                        r_cnt2  <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_tmr_zero) begin
                        r_timer <= r_timer - TMR_W'(1);
                    end else if (!w_act1 && !w_act2) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_step1 <= w_act1;
                        r_step2 <= w_act2;
                        r_timer <= T_HI;
                        r_state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    // An aborted pulse was never completed, so pos is left alone.
                    if (abort) begin
                        r_step1 <= 1'b0;
                        r_step2 <= 1'b0;
                        r_cnt1  <= '0;
                        r_cnt2  <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_tmr_zero) begin
                        r_timer <= r_timer - TMR_W'(1);
                    end else begin
                        r_step1 <= 1'b0;
                        r_step2 <= 1'b0;
                        if (w_act1) begin
                            r_cnt1 <= r_cnt1 - STEP_W'(1);
                            r_pos1 <= r_dir1 ? r_pos1 + POS_W'(1) : r_pos1 - POS_W'(1);
                        end
                        if (w_act2) begin
                            r_cnt2 <= r_cnt2 - STEP_W'(1);
                            r_pos2 <= r_dir2 ? r_pos2 + POS_W'(1) : r_pos2 - POS_W'(1);
                        end
                        r_timer <= T_LO;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        r_cnt1  <= '0;
                        r_cnt2  <= '0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (!w_tmr_zero) begin
                        r_timer <= r_timer - TMR_W'(1);
                    end else if (w_act1 || w_act2) begin
                        r_step1 <= w_act1;
                        r_step2 <= w_act2;
                        r_timer <= T_HI;
                        r_state <= S_HIGH;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_step1 <= 1'b0;
                    r_step2 <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign step1_out     = r_step1;
    assign step2_out     = r_step2;
    assign dir1_out      = r_dir1;
    assign dir2_out      = r_dir2;
    assign stepper_ready = r_ready;
    assign move_done     = r_done;
    assign sat           = r_sat;
    assign pos1          = r_pos1;
    assign pos2          = r_pos2;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Scoreboard bench for stepper_pulse_gen: each move pushes its expected waveform
// summary; a negedge monitor measures the move and compares when ready returns.
module tb_stepper_pulse_gen;

    localparam int DIR_SETUP = 2;
    localparam int PULSE_HI  = 3;
    localparam int PULSE_LO  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [63:0]        m1_steps = '0;
    logic [63:0]        m2_steps = '0;
    logic               dir1 = 1'b0;
    logic               dir2 = 1'b0;
    logic               step1_out, step2_out, dir1_out, dir2_out;
    logic               stepper_ready, move_done, sat;
    logic signed [31:0] pos1, pos2;

    always #5 clk = ~clk;

    stepper_pulse_gen #(
        .STEP_W(32), .POS_W(32),
        .DIR_SETUP(DIR_SETUP), .PULSE_HI(PULSE_HI), .PULSE_LO(PULSE_LO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .m1_steps(m1_steps), .m2_steps(m2_steps), .dir1(dir1), .dir2(dir2),
        .step1_out(step1_out), .step2_out(step2_out),
        .dir1_out(dir1_out), .dir2_out(dir2_out),
        .stepper_ready(stepper_ready), .move_done(move_done), .sat(sat),
        .pos1(pos1), .pos2(pos2)
    );

    typedef struct {
        int                 busy;
        int                 rises1, rises2, full1, full2, first;
        logic               d1, d2, sat;
        logic signed [31:0] pos1, pos2;
    } exp_t;

    exp_t               sb_q[$];
    logic signed [31:0] exp_pos1 = '0;
    logic signed [31:0] exp_pos2 = '0;
    int                 n_tests = 0;
    int                 n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected summary of a move that runs to completion, from the timing rules.
    task automatic push_full(input logic [63:0] m1, input logic d1,
                             input logic [63:0] m2, input logic d2);
        exp_t        e;
        logic [31:0] n1, n2;
        int          n;
        n1 = ((m1 >> 32) != 64'd0) ? 32'hFFFF_FFFF : m1[31:0];
        n2 = ((m2 >> 32) != 64'd0) ? 32'hFFFF_FFFF : m2[31:0];
        n  = (n1 > n2) ? int'(n1) : int'(n2);
        exp_pos1 = d1 ? exp_pos1 + n1 : exp_pos1 - n1;
        exp_pos2 = d2 ? exp_pos2 + n2 : exp_pos2 - n2;
        e.busy   = DIR_SETUP + n * (PULSE_HI + PULSE_LO) + 1;
        e.rises1 = int'(n1);
        e.rises2 = int'(n2);
        e.full1  = int'(n1);
        e.full2  = int'(n2);
        e.first  = (n > 0) ? DIR_SETUP : -1;
        e.d1     = d1;
        e.d2     = d2;
        e.sat    = ((m1 >> 32) != 64'd0) || ((m2 >> 32) != 64'd0);
        e.pos1   = exp_pos1;
        e.pos2   = exp_pos2;
        sb_q.push_back(e);
    endtask

    task automatic start_move(input logic [63:0] m1, input logic d1,
                              input logic [63:0] m2, input logic d2);
        @(posedge clk);
        #1;
        m1_steps = m1; dir1 = d1;
        m2_steps = m2; dir2 = d2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check({tag, "_timeout"}, 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_pos1 = '0;
        exp_pos2 = '0;
    endtask

    // Monitor: measures each busy window and compares it against the scoreboard.
    logic in_move = 1'b0;
    logic p1 = 1'b0, p2 = 1'b0;
    logic snap_d1, snap_d2, dir_moved;
    int   busy, r1, r2, f1, f2, w1, w2, first, done_cnt;

    always @(negedge clk) begin
        if (reset) begin
            in_move = 1'b0;
            p1 = 1'b0; p2 = 1'b0;
            w1 = 0; w2 = 0;
        end else begin
            if (!stepper_ready && !in_move) begin
                in_move = 1'b1;
                busy = 0; r1 = 0; r2 = 0; f1 = 0; f2 = 0; w1 = 0; w2 = 0;
                first = -1; done_cnt = 0;
                snap_d1 = dir1_out; snap_d2 = dir2_out; dir_moved = 1'b0;
            end
            if (in_move && !stepper_ready) begin
                if (first < 0 && ((step1_out && !p1) || (step2_out && !p2))) first = busy;
                if (step1_out && !p1) r1++;
                if (step2_out && !p2) r2++;
                if (step1_out) w1++;
                else if (p1) begin
                    if (w1 == PULSE_HI) f1++;
                    w1 = 0;
                end
                if (step2_out) w2++;
                else if (p2) begin
                    if (w2 == PULSE_HI) f2++;
                    w2 = 0;
                end
                if (move_done) done_cnt++;
                if (dir1_out !== snap_d1 || dir2_out !== snap_d2) dir_moved = 1'b1;
                busy++;
            end else if (in_move && stepper_ready) begin
                in_move = 1'b0;
                if (sb_q.size() == 0) begin
                    check("unexpected_move", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("busy_cycles", 64'(busy), 64'(e.busy));
                    check("step1_pulses", 64'(r1), 64'(e.rises1));
                    check("step2_pulses", 64'(r2), 64'(e.rises2));
                    check("step1_full_width", 64'(f1), 64'(e.full1));
                    check("step2_full_width", 64'(f2), 64'(e.full2));
                    check("first_step_delay", 64'(first), 64'(e.first));
                    check("move_done_count", 64'(done_cnt), 64'd1);
                    check("dir1_out", 64'(snap_d1), 64'(e.d1));
                    check("dir2_out", 64'(snap_d2), 64'(e.d2));
                    check("dir_stable", 64'(dir_moved), 64'd0);
                    check("sat", 64'(sat), 64'(e.sat));
                    check("pos1", 64'(pos1), 64'(e.pos1));
                    check("pos2", 64'(pos2), 64'(e.pos2));
                end
            end else if (move_done) begin
                check("done_while_idle", 64'(move_done), 64'd0);
            end
            p1 = step1_out;
            p2 = step2_out;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt;
        logic prev;

        // Reset state, then ten quiet idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(stepper_ready), 64'd1);
        check("rst_steps", 64'({step1_out, step2_out}), 64'd0);
        check("rst_dirs", 64'({dir1_out, dir2_out}), 64'd0);
        check("rst_done_sat", 64'({move_done, sat}), 64'd0);
        check("rst_pos1", 64'(pos1), 64'd0);
        check("rst_pos2", 64'(pos2), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("idle_ready", 64'(stepper_ready), 64'd1);
            check("idle_steps", 64'({step1_out, step2_out, move_done}), 64'd0);
        end

        // Abort in IDLE swallows a simultaneous start.
        @(posedge clk);
        #1;
        m1_steps = 64'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("idle_abort_ready", 64'(stepper_ready), 64'd1);
        end

        // Completed moves: mixed lengths and directions, then an empty move.
        push_full(64'd3, 1'b1, 64'd1, 1'b0);
        start_move(64'd3, 1'b1, 64'd1, 1'b0);
        wait_drain("move_3_1");
        push_full(64'd0, 1'b1, 64'd0, 1'b1);
        start_move(64'd0, 1'b1, 64'd0, 1'b1);
        wait_drain("move_0_0");
        push_full(64'd1, 1'b0, 64'd2, 1'b1);
        start_move(64'd1, 1'b0, 64'd2, 1'b1);
        wait_drain("move_1_2");

        // Saturating count, aborted during the LOW after the second pulse.
        do_reset();
        e = '{busy: 12, rises1: 2, rises2: 0, full1: 2, full2: 0, first: DIR_SETUP,
              d1: 1'b1, d2: 1'b0, sat: 1'b1, pos1: 32'sd2, pos2: 32'sd0};
        exp_pos1 = 32'sd2;
        sb_q.push_back(e);
        start_move(64'h1_0000_0005, 1'b1, 64'd0, 1'b0);
        cnt = 0; prev = 1'b0;
        for (int i = 0; i < 100 && cnt < 2; i++) begin
            @(posedge clk);
            #1;
            if (!step1_out && prev) cnt++;
            prev = step1_out;
        end
        if (cnt < 2) check("sat_fall_timeout", 64'(cnt), 64'd2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("sat_abort_done", 64'(move_done), 64'd1);
        wait_drain("sat_abort");
        push_full(64'd0, 1'b0, 64'd0, 1'b0);
        start_move(64'd0, 1'b0, 64'd0, 1'b0);
        wait_drain("sat_clear");

        // Abort in the 2nd cycle of the 2nd HIGH; a mid-move start is ignored.
        do_reset();
        e = '{busy: 10, rises1: 2, rises2: 0, full1: 1, full2: 0, first: DIR_SETUP,
              d1: 1'b1, d2: 1'b0, sat: 1'b0, pos1: 32'sd1, pos2: 32'sd0};
        exp_pos1 = 32'sd1;
        sb_q.push_back(e);
        start_move(64'd5, 1'b1, 64'd0, 1'b0);
        m1_steps = 64'd7; dir1 = 1'b0; start = 1'b1;
        cnt = 0; prev = 1'b0;
        for (int i = 0; i < 100 && cnt < 2; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (step1_out && !prev) cnt++;
            prev = step1_out;
        end
        if (cnt < 2) check("abort_rise_timeout", 64'(cnt), 64'd2);
        @(posedge clk);
        #1;
        check("abort_high_before", 64'(step1_out), 64'd1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_step1_fall", 64'(step1_out), 64'd0);
        check("abort_done", 64'(move_done), 64'd1);
        wait_drain("abort_move");

        // Asynchronous reset in the middle of a HIGH phase.
        start_move(64'd5, 1'b1, 64'd0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 50 && !step1_out; i++) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("rst_mid_high_seen", 64'(step1_out), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_step1", 64'(step1_out), 64'd0);
        check("async_rst_ready", 64'(stepper_ready), 64'd1);
        check("async_rst_pos1", 64'(pos1), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_pos1 = '0;
        exp_pos2 = '0;

        // Normal operation resumes after the reset.
        push_full(64'd2, 1'b1, 64'd0, 1'b0);
        start_move(64'd2, 1'b1, 64'd0, 1'b0);
        wait_drain("post_reset_move");

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stepper_pulse_gen.md
Name: stepper_pulse_gen

Overview:
- Dual-axis step/direction pulse generator on the motor side of the SCARA controller handshake.
- Consumes the per-move step counts and directions (m1_steps, m2_steps, dir1, dir2) produced by scara_controller.
- Emits timed STEP/DIR waveforms to two stepper drivers and returns stepper_ready to the controller.
- Keeps signed joint step position counters for debug and homing logic.

Parameters:
STEP_W, 32, internal step counter width; incoming 64-bit counts saturate to this width
POS_W, 32, width of signed position accumulators
DIR_SETUP, 50, cycles DIR is held stable before the first STEP edge (>=1)
PULSE_HI, 100, cycles STEP is high per pulse (>=1)
PULSE_LO, 100, cycles STEP is low between pulses (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; all state and outputs to reset values immediately
start  input  1  load strobe (driven by controller_ready); sampled only in IDLE
abort  input  1  synchronous move abort
m1_steps  input  64  joint 1 step count (unsigned)
m2_steps  input  64  joint 2 step count (unsigned)
dir1  input  1  joint 1 direction, 1 = positive
dir2  input  1  joint 2 direction, 1 = positive
step1_out  output  1  joint 1 STEP pulse
step2_out  output  1  joint 2 STEP pulse
dir1_out  output  1  joint 1 DIR to driver
dir2_out  output  1  joint 2 DIR to driver
stepper_ready  output  1  high only in IDLE; controller may issue a move
move_done  output  1  one-cycle pulse when a move completes or aborts
sat  output  1  set if either loaded count saturated; held until next load
pos1  output  POS_W  signed joint 1 step position
pos2  output  POS_W  signed joint 2 step position

Behaviour:
- Reset values: step*_out=0, dir*_out=0, stepper_ready=1, move_done=0, sat=0, pos*=0, state=IDLE.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE: if start & ~abort, latch counts and dirs. On the next cycle dir*_out take the new values, stepper_ready=0, and the state goes to SETUP with its timer loaded. start in any other state is ignored.
- Saturation: if m*_steps[63:STEP_W] != 0, load 2^STEP_W-1 and set sat. Otherwise sat=0 on load.
- SETUP: lasts exactly DIR_SETUP cycles. If both counts are 0, go to DONE; otherwise go to HIGH.
- HIGH: lasts PULSE_HI cycles. step_n_out=1 for each axis with remaining count >0. Axes already at 0 stay low.
- End of HIGH: each active axis decrements its count and updates pos_n by +1 (dir=1) or -1 (dir=0). Both axes update in the same cycle. Then go to LOW.
- LOW: lasts PULSE_LO cycles with both STEP outputs low. Then go to HIGH if either count is >0, else DONE.
- Axes run in lockstep on a shared timebase; the shorter axis simply stops pulsing.
- DONE: one cycle with move_done=1, then IDLE with stepper_ready=1.
- Busy time: stepper_ready is low for DIR_SETUP + N*(PULSE_HI+PULSE_LO) + 1 cycles, where N = max(n1, n2).
- Abort (SETUP/HIGH/LOW): next cycle STEP outputs go 0 and the state goes to DONE.
  - A truncated HIGH pulse is not counted in pos.
  - Remaining counts are discarded.
  - dir*_out hold their values.
- Abort in IDLE has no effect and suppresses a same-cycle start.
- Position wrap: pos* wraps modulo 2^POS_W (two's complement). No flag.
- dir*_out change only on a load, never mid-move.
- Reset mid-move: STEP outputs drop asynchronously and pos clears to 0.

Test Plan:
(bench params DIR_SETUP=2, PULSE_HI=3, PULSE_LO=2)
1. Reset release, idle 10 cycles -> stepper_ready=1, all STEP outputs 0, pos1=pos2=0, move_done never asserts.
2. start with m1=3,dir1=1, m2=1,dir2=0 -> step1 gives 3 pulses of 3 cycles high; step2 gives 1 pulse; first rising edge 2 cycles after DIR update; stepper_ready low 18 cycles; move_done one pulse; pos1=3, pos2=-1.
3. start with m1=0,m2=0 -> no STEP pulses; stepper_ready low 3 cycles; move_done pulses once.
4. start with m1=64'h1_0000_0005 -> sat=1, loaded count 32'hFFFFFFFF (abort after 2 pulses to bound the sim) -> pos1=2, move_done=1, stepper_ready returns.
5. abort asserted in the 2nd cycle of the 2nd HIGH phase of a 5-step move -> step1 falls the next cycle, pos1=1, move_done once, then IDLE; a start during the move was ignored.
6. Async reset asserted mid-HIGH -> step1_out=0 and stepper_ready=1 without a clock edge; pos1=0.
